// File: rtl/line_mem_responder_pkg.sv
// Shared types for the cache-line memory responder: LC-3b word/line types
// and the captured request operation.
package line_mem_responder_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  localparam int LINE_OFS = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RDWR  = 2'd2
  } mem_op_e;

  // A request with both strobes set is a write that also returns its data.
  function automatic mem_op_e decode_op(input logic rd, input logic wr);
    if (rd && wr) return OP_RDWR;
    if (wr)       return OP_WRITE;
    return OP_READ;
  endfunction

endpackage

// File: rtl/line_mem_responder_line_store.sv
// Line storage: NUM_LINES x LINE_BITS array with one write port and one
// asynchronous read port; lines never written (or cleared by reset) read as zero.
module line_mem_responder_line_store #(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 128,
  localparam int IDX      = $clog2(NUM_LINES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [IDX-1:0]       waddr,
  input  logic [LINE_BITS-1:0] wdata,
  input  logic [IDX-1:0]       raddr,
  output logic [LINE_BITS-1:0] rdata
);

  logic [LINE_BITS-1:0] lines_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (we) lines_q[waddr] <= wdata;
  end

  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[waddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  assign rdata = valid_q[raddr] ? lines_q[raddr] : '0;

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the shared cache-line port: accepts a level-held
// read/write, answers with a one-cycle mem_resp exactly LATENCY cycles later.
//
//   state     | meaning
//   S_IDLE    | waiting; a request here is captured and the timer loaded
//   S_BUSY    | timer counting down to the response cycle
//   S_RESP    | mem_resp high; a write commits at the end of this cycle
//   S_RECOVER | one dead cycle, requests ignored
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int LATENCY   = 8,
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [15:0]          mem_address,
  input  logic [LINE_BITS-1:0] mem_wdata,
  output logic                 mem_resp,
  output logic [LINE_BITS-1:0] mem_rdata
);

  localparam int OFS = (LINE_BITS == $bits(lc3b_line)) ? LINE_OFS : $clog2(LINE_BITS/8);
  localparam int IDX = $clog2(NUM_LINES);
  localparam int CW  = $clog2(LATENCY+1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RESP    = 2'd2,
    S_RECOVER = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  mem_op_e              op_q, op_d;
  logic [IDX-1:0]       idx_q, idx_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                 resp_q, resp_d;

  logic                 enter_resp;
  logic                 store_we;
  logic [IDX-1:0]       addr_idx;
  logic [LINE_BITS-1:0] store_rdata;
  logic                 unused_addr;

  assign addr_idx    = mem_address[OFS+IDX-1:OFS];
  assign unused_addr = ^{mem_address[15:OFS+IDX], mem_address[OFS-1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          op_d    = decode_op(mem_read, mem_write);
          idx_d   = addr_idx;
          wdata_d = mem_wdata;
          cnt_d   = CW'(LATENCY-1);
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:    state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Read data is registered on the edge into S_RESP so it is valid with mem_resp.
  always_comb begin
    resp_d  = enter_resp;
    rdata_d = rdata_q;
    if (enter_resp) begin
      case (op_d)
        OP_READ: rdata_d = store_rdata;
        OP_RDWR: rdata_d = wdata_d;
        default: rdata_d = rdata_q;
      endcase
    end
  end

  assign store_we = (state_q == S_RESP) && (op_q != OP_READ);

  line_mem_responder_line_store #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS)
  ) u_line_store (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (store_we),
    .waddr   (idx_q),
    .wdata   (wdata_q),
    .raddr   (idx_d),
    .rdata   (store_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: drivers push expected (cycle, rdata)
// pairs, a negedge monitor pops and compares on every mem_resp pulse.
module tb_line_mem_responder;

  localparam int LAT = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc        = 0;
  int   resp_seen  = 0;
  int   n_vec      = 0;
  int   n_fail     = 0;

  localparam logic [127:0] D_BEEF = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] W2     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] W3     = 128'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3_3C3C_3C3C;
  localparam logic [127:0] W5     = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  line_mem_responder #(
    .LATENCY   (LAT),
    .NUM_LINES (32),
    .LINE_BITS (128)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (reset_n && mem_resp) begin
      exp_t e;
      resp_seen++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: resp at cycle %0d, none required", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL resp_cycle: got cycle %0d, required %0d", cyc, e.cyc);
        end
        n_vec++;
        if (mem_rdata !== e.data) begin
          n_fail++;
          $display("FAIL rdata: got %h, required %h", mem_rdata, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    n_vec++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // hold=0 keeps the request up until mem_resp; otherwise drop it after hold cycles.
  task automatic xact(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [127:0] wd, input logic [127:0] exp, input int hold,
                      input int n_resp);
    int k, tgt;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd;
    k   = cyc;
    tgt = resp_seen + n_resp;
    for (int r = 0; r < n_resp; r++) exp_q.push_back('{cyc: k + LAT + r*(LAT+2), data: exp});
    for (int i = 0; i < 40 && resp_seen < tgt; i++) begin
      @(negedge clk); #1;
      if (hold != 0 && i + 1 == hold) begin
        mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '1;
      end
    end
    if (resp_seen < tgt) begin
      n_vec++; n_fail++;
      $display("FAIL resp_timeout: got %0d responses, required %0d", resp_seen, tgt);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;
  endtask

  initial begin
    reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_resp", {127'd0, mem_resp}, 128'd0);
    check("reset_rdata", mem_rdata, 128'd0);
    reset_n = 1'b1;

    xact(1'b1, 1'b0, 16'h0040, '0,     128'd0, 0, 1);
    xact(1'b0, 1'b1, 16'h0040, D_BEEF, 128'd0, 0, 1);
    xact(1'b1, 1'b0, 16'h0040, '0,     D_BEEF, 0, 1);
    xact(1'b1, 1'b0, 16'h0240, '0,     D_BEEF, 0, 1);
    xact(1'b1, 1'b0, 16'hFE4F, '0,     D_BEEF, 0, 1);
    xact(1'b1, 1'b0, 16'h0240, '0,     D_BEEF, 0, 2);
    xact(1'b0, 1'b1, 16'h00C0, W3,     D_BEEF, 2, 1);
    xact(1'b1, 1'b0, 16'h00C0, '0,     W3,     0, 1);
    xact(1'b1, 1'b1, 16'h0100, W2,     W2,     0, 1);
    xact(1'b1, 1'b0, 16'h0080, '0,     128'd0, 0, 1);
    xact(1'b1, 1'b0, 16'h0100, '0,     W2,     0, 1);

    // write aborted by reset at k+4: no response, storage cleared
    @(posedge clk); #1;
    mem_write = 1'b1; mem_address = 16'h0140; mem_wdata = W5;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_resp", {127'd0, mem_resp}, 128'd0);
    check("abort_rdata", mem_rdata, 128'd0);
    @(posedge clk); #1;
    mem_write = 1'b0; mem_wdata = '0;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);

    xact(1'b1, 1'b0, 16'h0140, '0, 128'd0, 0, 1);
    xact(1'b1, 1'b0, 16'h0040, '0, 128'd0, 0, 1);

    repeat (20) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++; n_fail++;
      $display("FAIL missing_resp: no response, required one at cycle %0d", e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
